// File: rtl/lpf_interp2.sv
// 2x polyphase interpolating low-pass filter: each accepted sample yields a phase-0 then a phase-1 output.
// Define LPF_INTERP2_SAT_EN to clamp results to [0, 2^DW-1]; otherwise the result wraps.
module lpf_interp2 #(
   parameter int DW = 10,
   parameter int CW = 10,
   parameter int FW = 15,
   parameter int SL = 7
) (
   input  logic                                  Clk,
   input  logic                                  Rst,
   input  logic [1:0][((FW+1)/2)-1:0][CW-1:0]    Coeff,
   input  logic [DW-1:0]                         DataIn,
   input  logic                                  DataInVld,
   output logic                                  DataInRdy,
   output logic [DW-1:0]                         DataOut,
   output logic                                  DataOutVld,
   input  logic                                  DataOutRdy,
   output logic                                  DataOutPh
);
   localparam int FN = (FW + 1) / 2;
   localparam int AW = DW + CW + $clog2(FN) + 1;
   localparam int RW = AW - SL;
   localparam logic signed [AW-1:0] HALF = AW'(2 ** (SL - 1));

   typedef enum logic [1:0] {IDLE, P0, P1} state_t;

   state_t                   state, state_nxt;
   logic [FN-1:0][DW-1:0]    dl, line_new, mac_x;
   logic [FN-1:0][CW-1:0]    mac_c;
   logic signed [AW-1:0]     acc, rnd;
   logic [RW-1:0]            r;
   logic [DW-1:0]            res;
   logic                     ph1_sel, accept, load_p1;
   logic                     unused_bits;

   assign line_new = {dl[FN-2:0], DataIn};

   // Phase 0 always sees the line as it will look after this accept; phase 1 sees the stored line.
   assign mac_x = ph1_sel ? dl : line_new;
   assign mac_c = ph1_sel ? Coeff[1] : Coeff[0];

   always_comb begin
      acc = '0;
      for (int k = 0; k < FN; k++)
         acc = acc + $signed({{(AW-DW){1'b0}}, mac_x[k]})
                   * $signed({{(AW-CW){mac_c[k][CW-1]}}, mac_c[k]});
      rnd = acc + HALF;
   end

   assign r = rnd[AW-1:SL];

`ifdef LPF_INTERP2_SAT_EN
   assign res         = r[RW-1] ? '0 : ((|r[RW-2:DW]) ? '1 : r[DW-1:0]);
   assign unused_bits = ^rnd[SL-1:0];
`else
   assign res         = r[DW-1:0];
   assign unused_bits = ^{rnd[SL-1:0], r[RW-1:DW]};
`endif

   always_comb begin
      state_nxt  = state;
      DataInRdy  = 1'b0;
      DataOutVld = 1'b0;
      DataOutPh  = 1'b0;
      ph1_sel    = 1'b0;
      case (state)
         IDLE: begin
            DataInRdy = 1'b1;
            if (DataInVld) state_nxt = P0;
         end
         P0: begin
            DataOutVld = 1'b1;
            ph1_sel    = 1'b1;
            if (DataOutRdy) state_nxt = P1;
         end
         P1: begin
            DataOutVld = 1'b1;
            DataOutPh  = 1'b1;
            DataInRdy  = DataOutRdy;
            if (DataOutRdy) state_nxt = DataInVld ? P0 : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept  = DataInVld & DataInRdy;
   assign load_p1 = (state == P0) & DataOutRdy;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state   <= IDLE;
         dl      <= '0;
         DataOut <= '0;
      end else begin
         state <= state_nxt;
         if (accept) dl <= line_new;
         if (accept | load_p1) DataOut <= res;
      end
   end
endmodule

// File: tb/tb_lpf_interp2.sv
// Directed bench for lpf_interp2; outputs compared as {vld, ph, in_rdy, data}.
module tb_lpf_interp2;
   logic               Clk = 1'b0;
   logic               Rst;
   logic [1:0][7:0][9:0] Coeff;
   logic [9:0]         DataIn;
   logic               DataInVld;
   logic               DataInRdy;
   logic [9:0]         DataOut;
   logic               DataOutVld;
   logic               DataOutRdy;
   logic               DataOutPh;

   int checks   = 0;
   int failures = 0;

`ifdef LPF_INTERP2_SAT_EN
   localparam logic [9:0] SAT_POS = 10'd1023;
   localparam logic [9:0] SAT_NEG = 10'd0;
`else
   localparam logic [9:0] SAT_POS = 10'd976;
   localparam logic [9:0] SAT_NEG = 10'd1019;
`endif

   lpf_interp2 dut (
      .Clk(Clk), .Rst(Rst), .Coeff(Coeff),
      .DataIn(DataIn), .DataInVld(DataInVld), .DataInRdy(DataInRdy),
      .DataOut(DataOut), .DataOutVld(DataOutVld), .DataOutRdy(DataOutRdy),
      .DataOutPh(DataOutPh)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_linear();
      Coeff       = '0;
      Coeff[0][0] = 10'd128;
      Coeff[1][0] = 10'd64;
      Coeff[1][1] = 10'd64;
   endtask

   task automatic test_reset();
      logic [12:0] obs;
      Rst = 1'b1; DataInVld = 1'b0; DataOutRdy = 1'b0; DataIn = '0;
      tick();
      Rst = 1'b0;
      #1;
      obs = {DataOutVld, DataOutPh, DataInRdy, DataOut};
      checks++;
      if (obs !== {1'b0, 1'b0, 1'b1, 10'd0}) begin
         failures++;
         $display("FAIL reset got=%h exp=%h", obs, {1'b0, 1'b0, 1'b1, 10'd0});
      end
      tick();
   endtask

   task automatic test_linear();
      logic [12:0] obs;
      logic [12:0] exp_t [5] = '{
         {1'b0, 1'b0, 1'b1, 10'd0},
         {1'b1, 1'b0, 1'b0, 10'd100},
         {1'b1, 1'b1, 1'b1, 10'd50},
         {1'b1, 1'b0, 1'b0, 10'd200},
         {1'b1, 1'b1, 1'b1, 10'd150}};
      logic [9:0] din_t [5] = '{10'd100, 10'd200, 10'd200, 10'd0, 10'd0};
      logic       vld_t [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      set_linear();
      for (int c = 0; c < 5; c++) begin
         DataIn = din_t[c]; DataInVld = vld_t[c]; DataOutRdy = 1'b1;
         #1;
         obs = {DataOutVld, DataOutPh, DataInRdy, DataOut};
         checks++;
         if (obs !== exp_t[c]) begin
            failures++;
            $display("FAIL linear[%0d] got=%h exp=%h", c, obs, exp_t[c]);
         end
         tick();
      end
      DataInVld = 1'b0;
      #1;
      checks++;
      if (DataOutVld !== 1'b0) begin
         failures++;
         $display("FAIL linear_idle got vld=%b exp vld=0", DataOutVld);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [12:0] obs;
      test_reset();
      set_linear();
      DataIn = 10'd100; DataInVld = 1'b1; DataOutRdy = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         DataIn = 10'd200; DataInVld = 1'b1; DataOutRdy = 1'b0;
         #1;
         obs = {DataOutVld, DataOutPh, DataInRdy, DataOut};
         checks++;
         if (obs !== {1'b1, 1'b0, 1'b0, 10'd100}) begin
            failures++;
            $display("FAIL bp_stall[%0d] got=%h exp=%h", c, obs, {1'b1, 1'b0, 1'b0, 10'd100});
         end
         tick();
      end
      DataOutRdy = 1'b1;
      tick();
      obs = {DataOutVld, DataOutPh, DataInRdy, DataOut};
      checks++;
      if (obs !== {1'b1, 1'b1, 1'b1, 10'd50}) begin
         failures++;
         $display("FAIL bp_ph1 got=%h exp=%h", obs, {1'b1, 1'b1, 1'b1, 10'd50});
      end
      tick();
      DataInVld = 1'b0;
      #1;
      obs = {DataOutVld, DataOutPh, DataInRdy, DataOut};
      checks++;
      if (obs !== {1'b1, 1'b0, 1'b0, 10'd200}) begin
         failures++;
         $display("FAIL bp_next got=%h exp=%h", obs, {1'b1, 1'b0, 1'b0, 10'd200});
      end
      tick();
      obs = {DataOutVld, DataOutPh, DataInRdy, DataOut};
      checks++;
      if (obs !== {1'b1, 1'b1, 1'b1, 10'd150}) begin
         failures++;
         $display("FAIL bp_next_ph1 got=%h exp=%h", obs, {1'b1, 1'b1, 1'b1, 10'd150});
      end
      tick();
   endtask

   task automatic test_saturation();
      test_reset();
      Coeff = '0;
      Coeff[0][0] = 10'd256;
      DataIn = 10'd1000; DataInVld = 1'b1; DataOutRdy = 1'b1;
      tick();
      DataInVld = 1'b0;
      checks++;
      if (DataOut !== SAT_POS || DataOutPh !== 1'b0) begin
         failures++;
         $display("FAIL sat_pos got=%0d ph=%b exp=%0d ph=0", DataOut, DataOutPh, SAT_POS);
      end
      tick();
      checks++;
      if (DataOut !== 10'd0 || DataOutPh !== 1'b1) begin
         failures++;
         $display("FAIL sat_pos_ph1 got=%0d ph=%b exp=0 ph=1", DataOut, DataOutPh);
      end
      tick();
      Coeff[0][0] = 10'h380;
      DataIn = 10'd5; DataInVld = 1'b1;
      tick();
      DataInVld = 1'b0;
      checks++;
      if (DataOut !== SAT_NEG) begin
         failures++;
         $display("FAIL sat_neg got=%0d exp=%0d", DataOut, SAT_NEG);
      end
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      logic [12:0] obs;
      test_reset();
      set_linear();
      DataIn = 10'd100; DataInVld = 1'b1; DataOutRdy = 1'b1;
      tick();
      DataInVld = 1'b0;
      tick();
      Rst = 1'b1; DataOutRdy = 1'b0;
      #1;
      obs = {DataOutVld, DataOutPh, DataInRdy, DataOut};
      checks++;
      if (obs !== {1'b1, 1'b1, 1'b0, 10'd50}) begin
         failures++;
         $display("FAIL rst_mid_pre got=%h exp=%h", obs, {1'b1, 1'b1, 1'b0, 10'd50});
      end
      tick();
      Rst = 1'b0;
      DataIn = 10'd200; DataInVld = 1'b1; DataOutRdy = 1'b1;
      #1;
      obs = {DataOutVld, DataOutPh, DataInRdy, DataOut};
      checks++;
      if (obs !== {1'b0, 1'b0, 1'b1, 10'd0}) begin
         failures++;
         $display("FAIL rst_mid_post got=%h exp=%h", obs, {1'b0, 1'b0, 1'b1, 10'd0});
      end
      tick();
      DataInVld = 1'b0;
      checks++;
      if (DataOut !== 10'd200 || DataOutPh !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_ph0 got=%0d ph=%b exp=200 ph=0", DataOut, DataOutPh);
      end
      tick();
      checks++;
      if (DataOut !== 10'd100 || DataOutPh !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_ph1 got=%0d ph=%b exp=100 ph=1", DataOut, DataOutPh);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [12:0] obs, exp_v;
      logic [9:0]  e;
      int          j, ph, nout;
      test_reset();
      set_linear();
      nout = 0;
      for (int c = 0; c < 18; c++) begin
         DataInVld = (c <= 14); DataIn = 10'(10 * (c / 2)); DataOutRdy = 1'b1;
         #1;
         if (c == 0)
            exp_v = {1'b0, 1'b0, 1'b1, 10'd0};
         else if (c == 17)
            exp_v = {1'b0, 1'b0, 1'b1, 10'd65};
         else begin
            j  = (c - 1) / 2;
            ph = (c - 1) % 2;
            e  = (ph == 0) ? 10'(10 * j) : ((j == 0) ? 10'd0 : 10'(10 * j - 5));
            exp_v = {1'b1, ph[0], (c % 2 == 0), e};
         end
         obs = {DataOutVld, DataOutPh, DataInRdy, DataOut};
         if (DataOutVld && DataOutRdy) nout++;
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL b2b[%0d] got=%h exp=%h", c, obs, exp_v);
         end
         tick();
      end
      checks++;
      if (nout != 16) begin
         failures++;
         $display("FAIL b2b_count got=%0d exp=16", nout);
      end
   endtask

   initial begin
      Coeff = '0;
      test_reset();
      test_linear();
      test_backpressure();
      test_saturation();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lpf_interp2.md
# lpf_interp2

2x polyphase interpolating low-pass filter for the luma path. It is the expansion-side counterpart of the FIR decimation stage. For each accepted input sample it emits two output samples: phase 0, then phase 1. Each output is a rounded, shifted and clamped MAC of per-phase coefficients over a sample delay line. It sits between the line-buffer read side and the output formatter, with valid/ready handshakes on both ports.

## Interface
- DW, 10: data width; samples are unsigned.
- CW, 10: coefficient width; coefficients are signed two's complement.
- FW, 15: prototype filter length. Taps per phase are FN = (FW+1)/2, so 8 by default.
- SL, 7: right-shift applied to the accumulator. Unity gain per phase is 2^SL.

- Clk  in  1  clock; every register is on its rising edge.
- Rst  in  1  reset, synchronous and active-high.
- Coeff  in  [1:0][FN-1:0][CW-1:0]  per-phase taps. Coeff[p][k] multiplies x[n-k]. Quasi-static: change only while idle.
- DataIn  in  DW  input sample.
- DataInVld  in  1  input valid.
- DataInRdy  out  1  input ready.
- DataOut  out  DW  interpolated sample.
- DataOutVld  out  1  output valid.
- DataOutRdy  in  1  downstream ready.
- DataOutPh  out  1  phase of the current DataOut: 0 or 1.

## Operation
- **Delay line:** dl[FN-1:0] of DW bits, dl[0] newest. It shifts only on an input handshake, where dl <= {dl[FN-2:0], DataIn}.
- **MAC:**
  - acc = sum over k of Coeff[p][k] * dl[k], signed, with dl zero-extended.
  - Accumulator width is DW+CW+clog2(FN)+1, so it never overflows.
  - Rounding: r = (acc + 2^(SL-1)) >>> SL, arithmetic shift.
- **Phase 0 is computed on the shifted-in line**, i.e. {dl[FN-2:0], DataIn} at the accept edge. Phase 1 is computed on dl after the shift.
- **FSM states:**
  - IDLE: no output pending. DataInRdy=1, DataOutVld=0.
  - P0: DataOut holds the phase-0 result. DataInRdy=0, DataOutVld=1, DataOutPh=0.
  - P1: DataOut holds the phase-1 result. DataOutVld=1, DataOutPh=1, DataInRdy=DataOutRdy.
- **Transitions:**
  - IDLE -> P0 on DataInVld.
  - P0 -> P1 on DataOutRdy.
  - P1 -> P0 on DataOutRdy & DataInVld. The output handshake and the new input accept happen in the same cycle.
  - P1 -> IDLE on DataOutRdy & !DataInVld.
  - Otherwise the state holds.
- **Stall:** DataOut and DataOutPh hold stable while DataOutVld=1 and DataOutRdy=0.
- **Input acceptance:** DataIn is consumed only when DataInVld & DataInRdy. DataInVld has no effect in P0, or in P1 with DataOutRdy=0.

## Timing
- **Reset:** Rst high at a rising edge gives, from the next cycle:
  - state=IDLE, dl=0, DataOut=0, DataOutVld=0, DataOutPh=0, DataInRdy=1.
  - Any pending output is discarded.
  - Rst overrides all handshakes in the same cycle.
- **Latency:** an input accepted at edge t presents phase 0 at t+1, i.e. DataOutVld is seen high in the cycle after the accept. Phase 1 appears at the edge following the phase-0 handshake.
- **Throughput:** with DataOutRdy=1 and DataInVld=1 continuously, one input is accepted every 2 cycles. DataOut then alternates phase 0 and phase 1 every cycle with no bubbles.
- **Startup:** the first FN-1 inputs after reset see zero history. There is no priming and no suppression of those outputs.
- **No combinational paths** from inputs to outputs except DataOutRdy -> DataInRdy in state P1.

## Configuration
- **Macro:** LPF_INTERP2_SAT_EN.
- **Defined:** r is clamped to [0, 2^DW-1]. Negative values give 0; values at or above 2^DW give 2^DW-1.
- **Undefined:** DataOut = r[DW-1:0], plain truncation with wrap-around and no clamp logic.
- FSM, latency and handshakes are identical in both builds.

## Test plan
All scenarios use the default parameters.

- **Linear interpolation:** Coeff[0]={128,0,...}, Coeff[1]={64,64,0,...}. Send 100 then 200 with DataOutRdy=1. Required outputs: 100(ph0), 50(ph1), 200(ph0), 150(ph1). DataInRdy pattern is 1,0,1,0.
- **Backpressure:** same coefficients. Hold DataOutRdy=0 for 5 cycles after the first accept. DataOut stays at 100, ph0, DataOutVld=1 and DataInRdy=0 throughout. After release, the sequence resumes 50 then 200 with nothing lost or duplicated.
- **Saturation, macro on:** Coeff[0][0]=256, input 1000 gives 1023. Coeff[0][0]=-128, input 5 gives 0.
- **Saturation, macro off:** the same two stimuli give 976 and 1019.
- **Reset mid-operation:** assert Rst while in state P1 holding 50. The next cycle shows DataOutVld=0 and DataInRdy=1. Sending 200 next gives ph0=200 and ph1=100, confirming the line is zeroed.
- **Back-to-back in P1:** DataInVld held high with DataOutRdy=1. The P1 handshake and the new accept occur in the same edge, and a continuous 8-sample ramp 0..70 step 10 yields 16 outputs with no idle cycles.
